// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler program loader.
package nibbler_pkg;
    localparam int          BYTE_W        = 8;
    localparam int          LEN_W         = 12;
    localparam int          ADDR_W_DEF    = 12;
    localparam int          DATA_W_DEF    = 8;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } load_state_t;
endpackage

// File: rtl/loader_checksum.sv
// Purpose: modulo-256 running sum of frame data bytes with a zero test against the check byte.
// Latency: sum updates one cycle after add; sum_zero is combinational on check_byte.
// Backpressure: none, driven purely by the caller's clear/add strobes.
module loader_checksum
    import nibbler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add,
    input  logic [BYTE_W-1:0] add_byte,
    input  logic [BYTE_W-1:0] check_byte,
    output logic              sum_zero
);
    logic [BYTE_W-1:0] sum;
    logic [BYTE_W-1:0] total;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + add_byte;
        end
    end

    assign total    = sum + check_byte;
    assign sum_zero = (total == '0);
endmodule

// File: rtl/prog_loader.sv
// Purpose: parse SYNC/LEN/DATA/CHECK frames from a byte link into program memory, then release the core.
// Latency: one mem_we cycle after each data beat; load_done/load_err one cycle after the deciding beat.
// Backpressure: byte_ready low in DONE and ERROR; only restart or reset leaves those states.
module prog_loader
    import nibbler_pkg::*;
#(
    parameter int         ADDR_W    = ADDR_W_DEF,
    parameter int         DATA_W    = DATA_W_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] loaded_count
);
    load_state_t       state, state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] count_inc;
    logic              beat;
    logic              is_sync;
    logic              last_data;
    logic              sum_zero;

    assign byte_ready = (state != DONE) && (state != ERROR);
    // restart wins over a simultaneous byte, so it never counts as a beat
    assign beat       = byte_valid && byte_ready && !restart;
    assign is_sync    = (byte_in == SYNC_BYTE);
    assign count_inc  = loaded_count + ADDR_W'(1);
    assign last_data  = (count_inc == ADDR_W'(len_q));

    loader_checksum u_checksum (
        .clk        (clk),
        .reset      (reset),
        .clear      (beat && (state == IDLE) && is_sync),
        .add        (beat && (state == DATA)),
        .add_byte   (byte_in),
        .check_byte (byte_in),
        .sum_zero   (sum_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = IDLE;
        end else if (beat) begin
            case (state)
                IDLE:    if (is_sync) state_nxt = LEN_HI;
                LEN_HI:  state_nxt = (byte_in[7:4] != 4'd0) ? ERROR : LEN_LO;
                LEN_LO:  state_nxt = ({len_q[LEN_W-1:8], byte_in} == '0) ? CHECK : DATA;
                DATA:    if (last_data) state_nxt = CHECK;
                CHECK:   state_nxt = sum_zero ? DONE : ERROR;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            loaded_count <= '0;
            len_q        <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            cpu_hold  <= (state_nxt != DONE);
            load_done <= (state_nxt == DONE);
            load_err  <= (state_nxt == ERROR);
            if (beat) begin
                case (state)
                    IDLE: begin
                        if (is_sync) begin
                            loaded_count <= '0;
                            len_q        <= '0;
                        end
                    end
                    LEN_HI: len_q[LEN_W-1:8] <= byte_in[3:0];
                    LEN_LO: len_q[7:0]       <= byte_in;
                    DATA: begin
                        mem_we       <= 1'b1;
                        mem_addr     <= loaded_count;
                        mem_data     <= DATA_W'(byte_in);
                        loaded_count <= count_inc;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed frame table plus hand-written abort, backpressure and reset sequences for prog_loader.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        restart;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [11:0] loaded_count;

    int checks = 0;
    int errors = 0;

    logic [11:0] wr_addr [$];
    logic [7:0]  wr_data [$];

    typedef struct {
        logic [95:0] seq;
        int          n;
        int          data_off;
        int          nwr;
        logic        exp_done;
        logic        exp_err;
        logic        exp_hold;
        logic        exp_rdy;
    } vec_t;

    vec_t tbl [6];

    prog_loader #(.ADDR_W(12), .DATA_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .restart      (restart),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .loaded_count (loaded_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bsel(input logic [95:0] s, input int i);
        return s[(11 - i) * 8 +: 8];
    endfunction

    // Tasks begin and end just after a rising edge.
    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic chk_writes(input string tag, input logic [95:0] s, input int off, input int nwr);
        chk({tag, " nwrites"}, wr_data.size(), nwr);
        for (int i = 0; i < nwr; i++) begin
            if (i < wr_data.size()) begin
                chk({tag, " waddr"}, wr_addr[i], i);
                chk({tag, " wdata"}, wr_data[i], bsel(s, off + i));
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, " hold"},  cpu_hold,   1'b1);
        chk({tag, " done"},  load_done,  1'b0);
        chk({tag, " err"},   load_err,   1'b0);
        chk({tag, " rdy"},   byte_ready, 1'b1);
        chk({tag, " we"},    mem_we,     1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{{8'hA5, 8'h00, 8'h07, 8'h40, 8'h44, 8'h40, 8'h4F, 8'hEF, 8'hA1, 8'h21, 8'h3C, 8'h00},
                   11, 3, 7, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{{8'hA5, 8'h00, 8'h07, 8'h40, 8'h44, 8'h40, 8'h4F, 8'hEF, 8'hA1, 8'h21, 8'h3D, 8'h00},
                   11, 3, 7, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   6, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   2, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{{8'hA5, 8'h00, 8'h02, 8'hA5, 8'h5B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   6, 3, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{{8'hA5, 8'h00, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   5, 3, 1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset with stray stimulus that must be ignored.
        reset      = 1'b0;
        byte_in    = 8'hA5;
        byte_valid = 1'b1;
        restart    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst hold",  cpu_hold,     1'b1);
        chk("rst done",  load_done,    1'b0);
        chk("rst err",   load_err,     1'b0);
        chk("rst we",    mem_we,       1'b0);
        chk("rst addr",  mem_addr,     12'h0);
        chk("rst data",  mem_data,     8'h00);
        chk("rst count", loaded_count, 12'h0);
        chk("rst rdy",   byte_ready,   1'b1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        restart    = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            clear_log();
            for (int i = 0; i < tbl[v].n; i++) send(bsel(tbl[v].seq, i), 0);
            @(negedge clk);
            chk("vec done",  load_done,    tbl[v].exp_done);
            chk("vec err",   load_err,     tbl[v].exp_err);
            chk("vec hold",  cpu_hold,     tbl[v].exp_hold);
            chk("vec rdy",   byte_ready,   tbl[v].exp_rdy);
            chk("vec count", loaded_count, tbl[v].nwr);
            @(posedge clk);
            #1;
            chk_writes("vec", tbl[v].seq, tbl[v].data_off, tbl[v].nwr);
            // A terminal state refuses further bytes, even a sync marker.
            send(8'hA5, 0);
            @(negedge clk);
            chk("vec stay done", load_done, tbl[v].exp_done);
            chk("vec stay err",  load_err,  tbl[v].exp_err);
            @(posedge clk);
            #1;
            do_restart();
            chk_idle("vec restart");
        end

        // Abort: restart arrives together with the 4th data byte.
        clear_log();
        for (int i = 0; i < 6; i++) send(bsel(tbl[0].seq, i), 0);
        byte_in    = 8'h4F;
        byte_valid = 1'b1;
        restart    = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        restart    = 1'b0;
        chk_idle("abort");
        repeat (3) @(posedge clk);
        #1;
        chk_writes("abort", tbl[0].seq, 3, 3);
        chk("abort err", load_err, 1'b0);

        // Good frame with random idle gaps between beats.
        clear_log();
        for (int i = 0; i < tbl[0].n; i++) send(bsel(tbl[0].seq, i), $urandom_range(0, 3));
        @(negedge clk);
        chk("bp done", load_done, 1'b1);
        chk("bp hold", cpu_hold,  1'b0);
        @(posedge clk);
        #1;
        chk_writes("bp", tbl[0].seq, 3, 7);
        do_restart();
        chk_idle("bp restart");

        // Reset while in DATA, with a beat offered on the reset edge.
        clear_log();
        for (int i = 0; i < 5; i++) send(bsel(tbl[0].seq, i), 0);
        reset      = 1'b0;
        byte_in    = 8'h40;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        @(negedge clk);
        chk("mrst hold",  cpu_hold,     1'b1);
        chk("mrst done",  load_done,    1'b0);
        chk("mrst err",   load_err,     1'b0);
        chk("mrst we",    mem_we,       1'b0);
        chk("mrst addr",  mem_addr,     12'h0);
        chk("mrst data",  mem_data,     8'h00);
        chk("mrst count", loaded_count, 12'h0);
        chk("mrst rdy",   byte_ready,   1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst nwrites", wr_data.size(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
